alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/sigma_pkg.sv | 26 ++
 rtl/alu_arbiter_alu.sv | 47 ++++
 rtl/alu_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sigma_pkg.sv
// sigma_pkg: shared ALU op encodings, arbiter state and flag types
package sigma_pkg;
    localparam int ALU_ARB_NPORTS = 2;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } alu_op_e;
    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } arb_state_e;
    typedef struct packed {
        logic zero;
        logic negative;
        logic overflow;
        logic carry;
    } alu_flags_t;
endpackage

// File: rtl/alu_arbiter_alu.sv
// alu: combinational 32-bit ALU with {zero, negative, overflow, carry} flags
// Ports: a, b operands; op in sigma_pkg encoding; result; flags.
// Unknown op codes give result 0 with only the zero flag set.
module alu
    import sigma_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] result,
    output alu_flags_t  flags
);
    logic [32:0] sum;
    logic [32:0] diff;
    logic        carry;
    logic        ovf;
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        // carry out of a + ~b + 1: set when no borrow occurs
        diff   = {1'b0, a} + {1'b0, ~b} + 33'd1;
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            ALU_ADD: begin
                result = sum[31:0];
                carry  = sum[32];
                ovf    = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            ALU_SUB: begin
                result = diff[31:0];
                carry  = diff[32];
                ovf    = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'b0, a < b};
            default:  result = '0;
        endcase
        flags = '{zero: ~|result, negative: result[31], overflow: ovf, carry: carry};
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin arbiter sharing one ALU, with per-port result slots
// Ports: clk, rst (sync, active-high); reqN_valid/ready, reqN_op1/op2/alu_op request side;
// rspN_valid/ready, rspN_result, rspN_flags response side for N = 0, 1.
// Macro ALU_ARB_FLAGS_EN: when defined, flags are captured per slot; otherwise rspN_flags is 0.
module alu_arbiter
    import sigma_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_op1,
    input  logic [31:0] req1_op1,
    input  logic [31:0] req0_op2,
    input  logic [31:0] req1_op2,
    input  logic [3:0]  req0_alu_op,
    input  logic [3:0]  req1_alu_op,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    input  logic        rsp0_ready,
    input  logic        rsp1_ready,
    output logic [31:0] rsp0_result,
    output logic [31:0] rsp1_result,
    output logic [3:0]  rsp0_flags,
    output logic [3:0]  rsp1_flags
);
    arb_state_e  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        port_q, port_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [3:0]  op_q, op_d;
    logic [ALU_ARB_NPORTS-1:0] rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_result_q [ALU_ARB_NPORTS];
    logic [31:0] rsp_result_d [ALU_ARB_NPORTS];
    logic [ALU_ARB_NPORTS-1:0] rsp_ready;
    logic [ALU_ARB_NPORTS-1:0] elig;
    logic        gnt;
    logic        accept;
    logic [31:0] alu_result;
    alu_flags_t  alu_flags;
`ifdef ALU_ARB_FLAGS_EN
    alu_flags_t  rsp_flags_q [ALU_ARB_NPORTS];
    alu_flags_t  rsp_flags_d [ALU_ARB_NPORTS];
`else
    logic        unused_flags;
    assign unused_flags = ^alu_flags;
`endif

    alu u_alu (
        .a      (op1_q),
        .b      (op2_q),
        .op     (op_q),
        .result (alu_result),
        .flags  (alu_flags)
    );

    assign rsp_ready = {rsp1_ready, rsp0_ready};

    always_comb begin
        // a full slot removes its port from arbitration without blocking the other
        elig         = {req1_valid & ~rsp_valid_q[1], req0_valid & ~rsp_valid_q[0]};
        gnt          = &elig ? ~last_grant_q : elig[1];
        accept       = (state_q == IDLE) && !rst && |elig;
        req0_ready   = accept & ~gnt;
        req1_ready   = accept & gnt;
        state_d      = state_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        op_d         = op_q;
        rsp_valid_d  = rsp_valid_q & ~rsp_ready;
        rsp_result_d = rsp_result_q;
`ifdef ALU_ARB_FLAGS_EN
        rsp_flags_d  = rsp_flags_q;
`endif
        if (accept) begin
            state_d      = EXEC;
            last_grant_d = gnt;
            port_d       = gnt;
            op1_d        = gnt ? req1_op1 : req0_op1;
            op2_d        = gnt ? req1_op2 : req0_op2;
            op_d         = gnt ? req1_alu_op : req0_alu_op;
        end
        // the granted slot was empty at acceptance, so this never collides with a drain
        if (state_q == EXEC) begin
            state_d              = IDLE;
            rsp_valid_d[port_q]  = 1'b1;
            rsp_result_d[port_q] = alu_result;
`ifdef ALU_ARB_FLAGS_EN
            rsp_flags_d[port_q]  = alu_flags;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            port_q       <= 1'b0;
            op1_q        <= '0;
            op2_q        <= '0;
            op_q         <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '{default: '0};
`ifdef ALU_ARB_FLAGS_EN
            rsp_flags_q  <= '{default: '0};
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            op_q         <= op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
`ifdef ALU_ARB_FLAGS_EN
            rsp_flags_q  <= rsp_flags_d;
`endif
        end
    end

    assign rsp0_valid  = rsp_valid_q[0];
    assign rsp1_valid  = rsp_valid_q[1];
    assign rsp0_result = rsp_result_q[0];
    assign rsp1_result = rsp_result_q[1];
`ifdef ALU_ARB_FLAGS_EN
    assign rsp0_flags  = rsp_flags_q[0];
    assign rsp1_flags  = rsp_flags_q[1];
`else
    assign rsp0_flags  = 4'b0000;
    assign rsp1_flags  = 4'b0000;
`endif
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
    import sigma_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_op1 = '0, req1_op1 = '0, req0_op2 = '0, req1_op2 = '0;
    logic [3:0]  req0_alu_op = '0, req1_alu_op = '0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [31:0] rsp0_result, rsp1_result;
    logic [3:0]  rsp0_flags, rsp1_flags;
    int          checks = 0;
    int          errors = 0;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_op1(req0_op1), .req1_op1(req1_op1),
        .req0_op2(req0_op2), .req1_op2(req1_op2),
        .req0_alu_op(req0_alu_op), .req1_alu_op(req1_alu_op),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
        .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
        .rsp0_result(rsp0_result), .rsp1_result(rsp1_result),
        .rsp0_flags(rsp0_flags), .rsp1_flags(rsp1_flags)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fx(input logic [3:0] f);
`ifdef ALU_ARB_FLAGS_EN
        return {28'b0, f};
`else
        return {28'b0, f & 4'b0000};
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        #1;
    endtask

    task automatic issue(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (p == 0) begin
            req0_valid = 1'b1; req0_alu_op = op; req0_op1 = a; req0_op2 = b;
        end else begin
            req1_valid = 1'b1; req1_alu_op = op; req1_op1 = a; req1_op2 = b;
        end
        #1;
        check(p == 0 ? "req0_ready" : "req1_ready", 32'(p == 0 ? req0_ready : req1_ready), 1);
        tick;
        if (p == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        #1;
    endtask

    initial begin
        int g;
        int exp_g;
        req0_valid = 1'b1;
        do_reset;
        rst = 1'b1;
        #1;
        check("ready_in_rst", 32'({req1_ready, req0_ready}), 0);
        check("rst_rsp_valid", 32'({rsp1_valid, rsp0_valid}), 0);
        check("rst_rsp0_result", rsp0_result, 0);
        check("rst_rsp1_result", rsp1_result, 0);
        check("rst_flags", 32'({rsp1_flags, rsp0_flags}), 0);
        check("rst_state", 32'(dut.state_q), 0);
        req0_valid = 1'b0;
        rst = 1'b0;
        tick;

        // ADD overflow into sign bit, latency T+2
        issue(0, ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        check("add_exec_valid", 32'(rsp0_valid), 0);
        tick;
        check("add_valid", 32'(rsp0_valid), 1);
        check("add_result", rsp0_result, 32'h8000_0000);
        check("add_flags", 32'(rsp0_flags), fx(4'b0110));
        tick;
        check("add_drained", 32'(rsp0_valid), 0);

        // round-robin from reset: both ports always valid
        do_reset;
        req0_valid = 1'b1; req0_alu_op = ALU_ADD; req0_op1 = 32'd1; req0_op2 = 32'd2;
        req1_valid = 1'b1; req1_alu_op = ALU_OR;  req1_op1 = 32'd4; req1_op2 = 32'd8;
        g = 0;
        exp_g = 0;
        #1;
        for (int c = 0; c < 8; c++) begin
            if (req0_ready | req1_ready) begin
                check("rr_onehot", 32'(req0_ready & req1_ready), 0);
                check("rr_grant", 32'(req1_ready), 32'(exp_g));
                exp_g ^= 1;
                g++;
            end
            tick;
        end
        check("rr_count", 32'(g), 4);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick;
        check("rr_drained", 32'({rsp1_valid, rsp0_valid}), 0);

        // port1 backpressured, port0 still served
        rsp1_ready = 1'b0;
        issue(1, ALU_XOR, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        tick;
        check("p1_full", 32'(rsp1_valid), 1);
        check("p1_result", rsp1_result, 32'hFFFF_FFFF);
        check("p1_flags", 32'(rsp1_flags), fx(4'b0100));
        req1_valid = 1'b1;
        issue(0, ALU_SUB, 32'd5, 32'd5);
        check("p1_blocked", 32'(req1_ready), 0);
        tick;
        check("sub_valid", 32'(rsp0_valid), 1);
        check("sub_result", rsp0_result, 0);
        check("sub_flags", 32'(rsp0_flags), fx(4'b1001));
        check("p1_hold", rsp1_result, 32'hFFFF_FFFF);
        check("p1_hold_valid", 32'(rsp1_valid), 1);
        req1_valid = 1'b0;
        rsp1_ready = 1'b1;
        tick;
        check("p1_drained", 32'({rsp1_valid, rsp0_valid}), 0);

        // reset during EXEC abandons the operation
        issue(0, ALU_SRA, 32'h8000_0000, 32'd4);
        req0_valid = 1'b1;
        rst = 1'b1;
        #1;
        check("ready_rst_exec", 32'(req0_ready), 0);
        tick;
        rst = 1'b0;
        req0_valid = 1'b0;
        #1;
        check("abandon_valid", 32'(rsp0_valid), 0);
        check("abandon_state", 32'(dut.state_q), 0);
        tick;
        check("abandon_valid2", 32'(rsp0_valid), 0);
        issue(0, ALU_SRA, 32'h8000_0000, 32'd4);
        tick;
        check("sra_valid", 32'(rsp0_valid), 1);
        check("sra_result", rsp0_result, 32'hF800_0000);
        check("sra_flags", 32'(rsp0_flags), fx(4'b0100));
        tick;

        // undefined op code
        issue(1, 4'hF, 32'hFFFF_FFFF, 32'h0000_0001);
        tick;
        check("bad_valid", 32'(rsp1_valid), 1);
        check("bad_result", rsp1_result, 0);
        check("bad_flags", 32'(rsp1_flags), fx(4'b1000));
        tick;

        // SLL uses only operand2[4:0]; hold under backpressure
        rsp0_ready = 1'b0;
        issue(0, ALU_SLL, 32'h0000_0001, 32'h0000_0021);
        tick;
        for (int c = 0; c < 3; c++) begin
            check("sll_hold_valid", 32'(rsp0_valid), 1);
            check("sll_hold_result", rsp0_result, 32'h0000_0002);
            check("sll_hold_flags", 32'(rsp0_flags), 0);
            tick;
        end
        rsp0_ready = 1'b1;
        tick;
        check("sll_cleared", 32'(rsp0_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
